color_grid_vote: RTL and testbench

COLOR_GRID_VOTE -- requirements
Module: color_grid_vote

---
 rtl/color_grid_vote.sv | 253 +++++++++++++++++++++++++
 tb/tb_color_grid_vote.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/color_grid_vote.sv
`default_nettype none
// ============================================================================
// Module   : color_grid_vote
// Purpose  : Per-region majority vote of pixel class codes over a GRID_X x
//            GRID_Y grid. Votes are scanned once per frame and published as
//            packed colours. Optional define COLOR_GRID_HYST_EN enables
//            two-frame confirmation before a region's colour changes.
// Revision : 1.0 - initial release
// ============================================================================
module color_grid_vote #(
    parameter int GRID_X     = 3,
    parameter int GRID_Y     = 3,
    parameter int FRAME_W    = 480,
    parameter int FRAME_H    = 480,
    parameter int COLOR_W    = 3,
    parameter int NUM_COLORS = 7,
    parameter int CNT_W      = 16,
    parameter int MIN_VOTES  = 1
) (
    input  logic                              i_clk,
    input  logic                              i_rstn,
    input  logic                              i_sof,
    input  logic                              i_valid,
    input  logic [COLOR_W-1:0]                i_color,
    output logic                              o_ready,
    output logic [GRID_X*GRID_Y*COLOR_W-1:0]  o_result,
    output logic                              o_result_valid,
    output logic                              o_busy
);

    localparam int c_REGIONS = GRID_X * GRID_Y;
    localparam int c_NCNT    = c_REGIONS * NUM_COLORS;
    localparam int c_RW      = FRAME_W / GRID_X;
    localparam int c_RH      = FRAME_H / GRID_Y;
    localparam int c_PX_W    = (c_RW > 1) ? $clog2(c_RW) : 1;
    localparam int c_PY_W    = (c_RH > 1) ? $clog2(c_RH) : 1;
    localparam int c_GX_W    = (GRID_X > 1) ? $clog2(GRID_X) : 1;
    localparam int c_GY_W    = (GRID_Y > 1) ? $clog2(GRID_Y) : 1;
    localparam int c_REG_W   = (c_REGIONS > 1) ? $clog2(c_REGIONS) : 1;
    localparam int c_IDX_W   = (c_NCNT > 1) ? $clog2(c_NCNT) : 1;

    localparam logic [1:0] c_ST_ACCUM   = 2'd0;
    localparam logic [1:0] c_ST_SCAN    = 2'd1;
    localparam logic [1:0] c_ST_PUBLISH = 2'd2;

    generate
        if ((FRAME_W % GRID_X) != 0 || (FRAME_H % GRID_Y) != 0 ||
            NUM_COLORS > (1 << COLOR_W)) begin : g_param_err
            $error("color_grid_vote: illegal parameter combination");
        end
    endgenerate

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [c_PX_W-1:0]  r_px;
    logic [c_GX_W-1:0]  r_rx;
    logic [c_PY_W-1:0]  r_py;
    logic [c_GY_W-1:0]  r_ry;
    logic [CNT_W-1:0]   r_cnt [c_NCNT];
    logic [c_IDX_W-1:0] r_scan_idx;
    logic [COLOR_W-1:0] r_scan_col;
    logic [c_REG_W-1:0] r_scan_reg;
    logic [CNT_W-1:0]   r_max_cnt;
    logic [COLOR_W-1:0] r_max_col;
    logic [COLOR_W-1:0] r_win [c_REGIONS];

    logic               w_ready;
    logic               w_accept;
    logic               w_px_last, w_rx_last, w_py_last, w_ry_last, w_last_pix;
    logic [c_REG_W-1:0] w_region;
    logic [c_IDX_W-1:0] w_cnt_idx;
    logic               w_color_ok;
    logic               w_inc;
    logic               w_clear;
    logic               w_scan_last;
    logic               w_col_last;
    logic [CNT_W-1:0]   w_scan_cnt;
    logic               w_take;
    logic [CNT_W-1:0]   w_new_max;
    logic [COLOR_W-1:0] w_new_col;
    logic [COLOR_W-1:0] w_region_win;
    logic               w_publish;

    assign w_ready    = (r_state == c_ST_ACCUM);
    assign w_accept   = i_valid && w_ready && !i_sof;
    assign w_px_last  = (r_px == c_PX_W'(c_RW - 1));
    assign w_rx_last  = (r_rx == c_GX_W'(GRID_X - 1));
    assign w_py_last  = (r_py == c_PY_W'(c_RH - 1));
    assign w_ry_last  = (r_ry == c_GY_W'(GRID_Y - 1));
    assign w_last_pix = w_px_last && w_rx_last && w_py_last && w_ry_last;
    assign w_region   = c_REG_W'(int'(r_ry) * GRID_X + int'(r_rx));
    assign w_cnt_idx  = c_IDX_W'(int'(w_region) * NUM_COLORS + int'(i_color));
    assign w_color_ok = (int'(i_color) < NUM_COLORS);
    assign w_inc      = w_accept && w_color_ok;
    assign w_clear    = i_sof || (r_state == c_ST_PUBLISH);

    // Scan walks counters region-major; the first colour of each region
    // seeds the running max so strict '>' leaves ties on the lowest code.
    assign w_scan_last  = (r_scan_idx == c_IDX_W'(c_NCNT - 1));
    assign w_col_last   = (r_scan_col == COLOR_W'(NUM_COLORS - 1));
    assign w_scan_cnt   = r_cnt[r_scan_idx];
    assign w_take       = (r_scan_col == '0) || (w_scan_cnt > r_max_cnt);
    assign w_new_max    = w_take ? w_scan_cnt : r_max_cnt;
    assign w_new_col    = w_take ? r_scan_col : r_max_col;
    assign w_region_win = (int'(w_new_max) < MIN_VOTES) ? '0 : w_new_col;
    assign w_publish    = (r_state == c_ST_SCAN) && w_scan_last && !i_sof;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state <= c_ST_ACCUM;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (i_sof) begin
            w_next_state = c_ST_ACCUM;
        end else begin
            case (r_state)
                c_ST_ACCUM:   if (w_accept && w_last_pix) w_next_state = c_ST_SCAN;
                c_ST_SCAN:    if (w_scan_last) w_next_state = c_ST_PUBLISH;
                c_ST_PUBLISH: w_next_state = c_ST_ACCUM;
                default:      w_next_state = c_ST_ACCUM;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_px <= '0;
            r_rx <= '0;
            r_py <= '0;
            r_ry <= '0;
        end else if (i_sof) begin
            r_px <= '0;
            r_rx <= '0;
            r_py <= '0;
            r_ry <= '0;
        end else if (w_accept) begin
            if (w_px_last) begin
                r_px <= '0;
                if (w_rx_last) begin
                    r_rx <= '0;
                    if (w_py_last) begin
                        r_py <= '0;
                        r_ry <= w_ry_last ? '0 : r_ry + 1'b1;
                    end else begin
                        r_py <= r_py + 1'b1;
                    end
                end else begin
                    r_rx <= r_rx + 1'b1;
                end
            end else begin
                r_px <= r_px + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            for (int i = 0; i < c_NCNT; i++) r_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < c_NCNT; i++) begin
                if (w_clear) begin
                    r_cnt[i] <= '0;
                end else if (w_inc && (w_cnt_idx == c_IDX_W'(i)) &&
                             (r_cnt[i] != {CNT_W{1'b1}})) begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_scan_idx <= '0;
            r_scan_col <= '0;
            r_scan_reg <= '0;
            r_max_cnt  <= '0;
            r_max_col  <= '0;
            for (int i = 0; i < c_REGIONS; i++) r_win[i] <= '0;
        end else if (i_sof || (r_state != c_ST_SCAN)) begin
            r_scan_idx <= '0;
            r_scan_col <= '0;
            r_scan_reg <= '0;
            r_max_cnt  <= '0;
            r_max_col  <= '0;
        end else begin
            r_scan_idx <= r_scan_idx + 1'b1;
            r_max_cnt  <= w_new_max;
            r_max_col  <= w_new_col;
            if (w_col_last) begin
                r_win[r_scan_reg] <= w_region_win;
                r_scan_col        <= '0;
                r_scan_reg        <= r_scan_reg + 1'b1;
            end else begin
                r_scan_col <= r_scan_col + 1'b1;
            end
        end
    end

    // The last region's winner is still combinational when publishing.
    generate
        for (genvar g = 0; g < c_REGIONS; g++) begin : g_region
            logic [COLOR_W-1:0] w_pub_win;
            logic [COLOR_W-1:0] r_field;

            assign w_pub_win = (g == c_REGIONS - 1) ? w_region_win : r_win[g];
`ifdef COLOR_GRID_HYST_EN
            logic [COLOR_W-1:0] r_pend;
            logic               r_pend_vld;

            always_ff @(posedge i_clk or negedge i_rstn) begin
                if (!i_rstn) begin
                    r_field    <= '0;
                    r_pend     <= '0;
                    r_pend_vld <= 1'b0;
                end else if (i_sof) begin
                    r_pend     <= '0;
                    r_pend_vld <= 1'b0;
                end else if (w_publish) begin
                    if (w_pub_win == r_field) begin
                        r_pend_vld <= 1'b0;
                    end else if (r_pend_vld && (r_pend == w_pub_win)) begin
                        r_field    <= w_pub_win;
                        r_pend_vld <= 1'b0;
                    end else begin
                        r_pend     <= w_pub_win;
                        r_pend_vld <= 1'b1;
                    end
                end
            end
`else
            always_ff @(posedge i_clk or negedge i_rstn) begin
                if (!i_rstn) begin
                    r_field <= '0;
                end else if (w_publish) begin
                    r_field <= w_pub_win;
                end
            end
`endif
            assign o_result[(c_REGIONS-1-g)*COLOR_W +: COLOR_W] = r_field;
        end
    endgenerate

    assign o_ready        = w_ready;
    assign o_result_valid = (r_state == c_ST_PUBLISH);
    assign o_busy         = !w_ready;

endmodule
`default_nettype wire

// File: tb/tb_color_grid_vote.sv
`default_nettype none
// ============================================================================
// Module   : tb_color_grid_vote
// Purpose  : Self-checking bench for color_grid_vote on a 6x6 frame, 3x3 grid,
//            with two instances (MIN_VOTES 1 and 3) sharing one stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_color_grid_vote;

    localparam int c_NPIX = 36;
    localparam int c_NREG = 9;
    localparam int c_NC   = 7;

    logic        clk = 1'b0;
    logic        rstn;
    logic        sof;
    logic        valid;
    logic [2:0]  color;
    logic        rdy_a, rv_a, busy_a;
    logic [26:0] res_a;
    logic        rdy_b, rv_b, busy_b;
    logic [26:0] res_b;

    int checks   = 0;
    int failures = 0;
    int pulses_a = 0;
    int pulses_b = 0;

    int fr [c_NPIX];
    int m_field [2][c_NREG];
    int m_pend  [2][c_NREG];
    bit m_pvld  [2][c_NREG];

    always #5 clk = ~clk;

    color_grid_vote #(
        .GRID_X(3), .GRID_Y(3), .FRAME_W(6), .FRAME_H(6), .COLOR_W(3),
        .NUM_COLORS(7), .CNT_W(16), .MIN_VOTES(1)
    ) dut_a (
        .i_clk(clk), .i_rstn(rstn), .i_sof(sof), .i_valid(valid), .i_color(color),
        .o_ready(rdy_a), .o_result(res_a), .o_result_valid(rv_a), .o_busy(busy_a)
    );

    color_grid_vote #(
        .GRID_X(3), .GRID_Y(3), .FRAME_W(6), .FRAME_H(6), .COLOR_W(3),
        .NUM_COLORS(7), .CNT_W(16), .MIN_VOTES(3)
    ) dut_b (
        .i_clk(clk), .i_rstn(rstn), .i_sof(sof), .i_valid(valid), .i_color(color),
        .o_ready(rdy_b), .o_result(res_b), .o_result_valid(rv_b), .o_busy(busy_b)
    );

    always @(negedge clk) begin
        if (rv_a) pulses_a++;
        if (rv_b) pulses_b++;
    end

    // Reference: plain vote tally over the frame buffer, raster index p.
    function automatic int winner(input int mv, input int reg_i);
        int votes [8];
        int best;
        int bc;
        for (int c = 0; c < 8; c++) votes[c] = 0;
        for (int p = 0; p < c_NPIX; p++) begin
            if ((((p / 6) / 2) * 3 + (p % 6) / 2) == reg_i && fr[p] < c_NC)
                votes[fr[p]]++;
        end
        best = -1;
        bc   = 0;
        for (int c = 0; c < c_NC; c++) begin
            if (votes[c] > best) begin
                best = votes[c];
                bc   = c;
            end
        end
        return (best < mv) ? 0 : bc;
    endfunction

    task automatic model_publish();
        int w;
        for (int d = 0; d < 2; d++) begin
            for (int r = 0; r < c_NREG; r++) begin
                w = winner((d == 0) ? 1 : 3, r);
`ifdef COLOR_GRID_HYST_EN
                if (w == m_field[d][r]) begin
                    m_pvld[d][r] = 0;
                end else if (m_pvld[d][r] && m_pend[d][r] == w) begin
                    m_field[d][r] = w;
                    m_pvld[d][r]  = 0;
                end else begin
                    m_pend[d][r] = w;
                    m_pvld[d][r] = 1;
                end
`else
                m_field[d][r] = w;
`endif
            end
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int r = 0; r < c_NREG; r++) begin
                m_field[d][r] = 0;
                m_pend[d][r]  = 0;
                m_pvld[d][r]  = 0;
            end
        end
    endtask

    task automatic model_sof();
        for (int d = 0; d < 2; d++) begin
            for (int r = 0; r < c_NREG; r++) begin
                m_pend[d][r] = 0;
                m_pvld[d][r] = 0;
            end
        end
    endtask

    function automatic logic [26:0] exp_pack(input int d);
        logic [26:0] v;
        v = '0;
        for (int r = 0; r < c_NREG; r++) v[(8 - r) * 3 +: 3] = 3'(m_field[d][r]);
        return v;
    endfunction

    task automatic fill_random();
        for (int p = 0; p < c_NPIX; p++) fr[p] = $urandom_range(0, 7);
    endtask

    task automatic fill_const(input int c);
        for (int p = 0; p < c_NPIX; p++) fr[p] = c;
    endtask

    task automatic send_pixels(input int n, input bit gaps);
        int g;
        for (int p = 0; p < n; p++) begin
            g = gaps ? $urandom_range(0, 2) : 0;
            repeat (g) begin
                @(negedge clk);
                valid = 1'b0;
                color = 3'($urandom);
            end
            @(negedge clk);
            valid = 1'b1;
            color = 3'(fr[p]);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            valid = 1'b0;
        end
    endtask

    // Called right after the last pixel was driven; counts negedges to the pulse.
    task automatic wait_publish(input string name, input bit keep_valid);
        int  k       = 0;
        int  lo      = 0;
        bit  seen    = 0;
        int  p0      = pulses_a;
        logic [26:0] ea, eb;
        while (!seen && k < 200) begin
            @(negedge clk);
            k++;
            if (!rdy_a) lo++;
            if (rv_a) seen = 1;
            if (keep_valid && !seen) begin
                valid = 1'b1;
                color = 3'($urandom);
            end else begin
                valid = 1'b0;
            end
        end
        checks++;
        if (k !== 64 || !seen) begin
            failures++;
            $display("FAIL %s latency: got %0d cycles (seen=%0d), want 64", name, k, seen);
        end
        checks++;
        if (lo !== 64) begin
            failures++;
            $display("FAIL %s ready_low: got %0d cycles, want 64", name, lo);
        end
        model_publish();
        ea = exp_pack(0);
        eb = exp_pack(1);
        checks++;
        if (res_a !== ea || busy_a !== 1'b1) begin
            failures++;
            $display("FAIL %s result_mv1: got %h busy=%b, want %h busy=1", name, res_a, busy_a, ea);
        end
        checks++;
        if (res_b !== eb || rv_b !== 1'b1) begin
            failures++;
            $display("FAIL %s result_mv3: got %h valid=%b, want %h valid=1", name, res_b, rv_b, eb);
        end
        @(negedge clk);
        checks++;
        if (rv_a !== 1'b0 || rdy_a !== 1'b1 || pulses_a !== p0 + 1) begin
            failures++;
            $display("FAIL %s after_pulse: valid=%b ready=%b pulses=%0d, want 0 1 %0d",
                     name, rv_a, rdy_a, pulses_a, p0 + 1);
        end
    endtask

    task automatic test_reset();
        rstn  = 1'b0;
        sof   = 1'b0;
        valid = 1'b0;
        color = '0;
        model_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (rdy_a !== 1'b1 || busy_a !== 1'b0 || rv_a !== 1'b0 || res_a !== 27'd0) begin
            failures++;
            $display("FAIL reset_state: ready=%b busy=%b valid=%b result=%h, want 1 0 0 0",
                     rdy_a, busy_a, rv_a, res_a);
        end
        rstn = 1'b1;
        @(negedge clk);
        checks++;
        if (rdy_a !== 1'b1 || busy_a !== 1'b0 || res_b !== 27'd0) begin
            failures++;
            $display("FAIL reset_release: ready=%b busy=%b result_mv3=%h, want 1 0 0",
                     rdy_a, busy_a, res_b);
        end
    endtask

    task automatic test_uniform();
        fill_const(1);
        send_pixels(c_NPIX, 0);
        wait_publish("uniform", 0);
`ifndef COLOR_GRID_HYST_EN
        checks++;
        if (res_a !== {9{3'd1}}) begin
            failures++;
            $display("FAIL uniform_literal: got %h, want %h", res_a, {9{3'd1}});
        end
`endif
    endtask

    task automatic test_tie();
        fill_const(5);
        fr[14] = 2; fr[15] = 2; fr[20] = 3; fr[21] = 3;
        send_pixels(c_NPIX, 1);
        wait_publish("tie", 0);
`ifndef COLOR_GRID_HYST_EN
        checks++;
        if (res_a !== {3'd5, 3'd5, 3'd5, 3'd5, 3'd2, 3'd5, 3'd5, 3'd5, 3'd5}) begin
            failures++;
            $display("FAIL tie_literal: got %h", res_a);
        end
`endif
    endtask

    task automatic test_sof_abort();
        int p0;
        fill_random();
        send_pixels(20, 0);
        @(negedge clk);
        sof   = 1'b1;
        valid = 1'b1;
        color = 3'd4;
        model_sof();
        @(negedge clk);
        sof   = 1'b0;
        valid = 1'b0;
        p0    = pulses_a;
        idle(80);
        checks++;
        if (pulses_a !== p0 || busy_a !== 1'b0 || rdy_a !== 1'b1) begin
            failures++;
            $display("FAIL sof_abort_idle: pulses=%0d busy=%b ready=%b, want %0d 0 1",
                     pulses_a, busy_a, rdy_a, p0);
        end
        fill_const(6);
        send_pixels(c_NPIX, 0);
        wait_publish("sof_frame", 0);
    endtask

    task automatic test_scan_hold();
        fill_random();
        send_pixels(c_NPIX, 0);
        wait_publish("scan_hold", 1);
        fill_random();
        send_pixels(c_NPIX, 1);
        wait_publish("after_hold", 0);
    endtask

    task automatic test_min_votes();
        fill_random();
        fr[0] = 1; fr[1] = 7; fr[6] = 7; fr[7] = 2;
        send_pixels(c_NPIX, 0);
        wait_publish("min_votes", 0);
`ifndef COLOR_GRID_HYST_EN
        checks++;
        if (res_b[26:24] !== 3'd0 || res_a[26:24] !== 3'd1) begin
            failures++;
            $display("FAIL min_votes_field0: mv3=%0d mv1=%0d, want 0 1", res_b[26:24], res_a[26:24]);
        end
`endif
    endtask

    task automatic test_random();
        for (int f = 0; f < 4; f++) begin
            fill_random();
            send_pixels(c_NPIX, 1);
            wait_publish("random", 0);
        end
    endtask

    task automatic test_reset_mid();
        int p0;
        fill_random();
        send_pixels(10, 0);
        @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        model_reset();
        checks++;
        if (res_a !== 27'd0 || rdy_a !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_frame: result=%h ready=%b, want 0 1", res_a, rdy_a);
        end
        @(negedge clk);
        rstn  = 1'b1;
        valid = 1'b0;
        fill_random();
        send_pixels(c_NPIX, 0);
        idle(10);
        #2 rstn = 1'b0;
        #1;
        checks++;
        if (busy_a !== 1'b0 || rdy_a !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_scan: busy=%b ready=%b, want 0 1", busy_a, rdy_a);
        end
        @(negedge clk);
        rstn = 1'b1;
        p0   = pulses_a;
        idle(80);
        checks++;
        if (pulses_a !== p0 || res_a !== 27'd0) begin
            failures++;
            $display("FAIL reset_mid_scan_pulse: pulses=%0d result=%h, want %0d 0", pulses_a, res_a, p0);
        end
        fill_random();
        send_pixels(c_NPIX, 1);
        wait_publish("after_reset", 0);
    endtask

    task automatic test_hyst_sequence();
        int          vals [4];
        int          expv [4];
        logic [2:0]  e3;
        vals = '{1, 1, 2, 2};
`ifdef COLOR_GRID_HYST_EN
        expv = '{0, 1, 1, 2};
`else
        expv = '{1, 1, 2, 2};
`endif
        @(negedge clk);
        rstn = 1'b0;
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
        for (int f = 0; f < 4; f++) begin
            fill_const(vals[f]);
            send_pixels(c_NPIX, 0);
            wait_publish("hyst", 0);
            e3 = 3'(expv[f]);
            checks++;
            if (res_a !== {9{e3}}) begin
                failures++;
                $display("FAIL hyst_frame%0d: got %h, want %h", f + 1, res_a, {9{e3}});
            end
        end
    endtask

    initial begin
        test_reset();
        test_uniform();
        test_tie();
        test_sof_abort();
        test_scan_hold();
        test_min_votes();
        test_random();
        test_reset_mid();
        test_hyst_sequence();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
